// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the shared-ALU arbiter slice: operand width, the
// 4-bit ALU operation encoding, the arbiter state encoding and a legality
// helper used by the ALU.
// Ports: none (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // Codes 8..15 have no operation assigned.
    function automatic logic alu_op_legal(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_32bit.sv
// -----------------------------------------------------------------------------
// alu_32bit
// Purely combinational 32-bit ALU. Illegal operation codes produce a zero
// result and raise o_err.
// Ports:
//   i_op  [3:0]      operation select (alu_pkg encoding)
//   i_a   [XLEN-1:0] operand 1
//   i_b   [XLEN-1:0] operand 2 (shifts use bits [4:0] only)
//   o_y   [XLEN-1:0] result
//   o_err            illegal operation flag
// -----------------------------------------------------------------------------
module alu_32bit
    import alu_pkg::*;
(
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_y,
    output logic            o_err
);

    logic        [4:0]      w_shamt;
    logic signed [XLEN-1:0] w_a_s;

    assign w_shamt = i_b[4:0];
    assign w_a_s   = $signed(i_a);

    always_comb begin
        o_y   = '0;
        o_err = 1'b0;
        if (!alu_op_legal(i_op)) begin
            o_err = 1'b1;
        end else begin
            case (i_op)
                ALU_AND: o_y = i_a & i_b;
                ALU_OR:  o_y = i_a | i_b;
                ALU_ADD: o_y = i_a + i_b;
                ALU_XOR: o_y = i_a ^ i_b;
                ALU_SLL: o_y = i_a << w_shamt;
                ALU_SRL: o_y = i_a >> w_shamt;
                ALU_SUB: o_y = i_a - i_b;
                ALU_SRA: o_y = w_a_s >>> w_shamt;
                default: o_y = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
// Round-robin arbiter/sequencer that shares one alu_32bit between two
// requesters. At most one result is held at a time; it is returned on the
// owning port's response channel and a new request can be accepted in the same
// cycle the held result is consumed, giving one op per cycle.
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   req_valid_i/ready_o     per-port request handshake [NREQ]
//   req_op_i                per-port op select, port k at [4k+3:4k]
//   req_a_i, req_b_i        per-port operands, port k at [XLEN*k +: XLEN]
//   rsp_valid_o/ready_i     per-port response handshake [NREQ], one-hot
//   rsp_data_o              registered result shared by both ports
//   rsp_err_o               held result came from an illegal op
// Only NREQ=2 and XLEN=32 are supported.
// -----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*4-1:0]    req_op_i,
    input  logic [NREQ*XLEN-1:0] req_a_i,
    input  logic [NREQ*XLEN-1:0] req_b_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [XLEN-1:0]      rsp_data_o,
    output logic                 rsp_err_o
);

    import alu_pkg::*;

    state_t          r_state;
    logic            r_prio;
    logic            r_owner;
    logic [XLEN-1:0] r_data;
    logic            r_err;

    logic [NREQ-1:0] w_grant;
    logic            w_rsp_hs;
    logic            w_slot_free;
    logic            w_accept;
    logic            w_sel;
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_y;
    logic            w_alu_err;

    // A lone requester always wins; under contention the pointer decides.
    always_comb begin
        w_grant = req_valid_i;
        if (&req_valid_i) begin
            w_grant = r_prio ? 2'b10 : 2'b01;
        end
    end

    assign w_rsp_hs    = (r_state == ST_RESP) && rsp_ready_i[r_owner];
    // The result register can take a new value if empty or drained this cycle;
    // this keeps rsp_ready_i -> req_ready_o combinational.
    assign w_slot_free = (r_state == ST_IDLE) || w_rsp_hs;
    assign req_ready_o = w_grant & {NREQ{w_slot_free}};
    assign w_accept    = |(req_valid_i & req_ready_o);
    assign w_sel       = w_grant[1];

    assign w_op = w_sel ? req_op_i[7:4]           : req_op_i[3:0];
    assign w_a  = w_sel ? req_a_i[2*XLEN-1:XLEN]  : req_a_i[XLEN-1:0];
    assign w_b  = w_sel ? req_b_i[2*XLEN-1:XLEN]  : req_b_i[XLEN-1:0];

    alu_32bit u_alu (
        .i_op  (w_op),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_y   (w_y),
        .o_err (w_alu_err)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_data  <= w_y;
            r_err   <= w_alu_err;
            r_owner <= w_sel;
            r_prio  <= ~w_sel;
            r_state <= ST_RESP;
        end else if (w_rsp_hs) begin
            r_state <= ST_IDLE;
        end
    end

    assign rsp_valid_o = (r_state == ST_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data_o  = r_data;
    assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_alu_share_arb.sv
`timescale 1ns/1ps
module tb_alu_share_arb;

    localparam int NREQ = 2;
    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ*4-1:0]    req_op_i;
    logic [NREQ*XLEN-1:0] req_a_i;
    logic [NREQ*XLEN-1:0] req_b_i;
    logic [NREQ-1:0]      rsp_valid_o;
    logic [NREQ-1:0]      rsp_ready_i;
    logic [XLEN-1:0]      rsp_data_o;
    logic                 rsp_err_o;

    always #5 clk = ~clk;

    alu_share_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o)
    );

    typedef struct packed { logic [3:0] op; logic [31:0] a; logic [31:0] b; } txn_t;
    typedef struct packed { logic [31:0] data; logic err; } exp_t;
    typedef struct { logic port; logic [31:0] data; logic err; int cyc; } rsp_rec_t;
    typedef struct { logic port; int cyc; } acc_rec_t;

    txn_t     pend_q[2][$];
    exp_t     exp_q[2][$];
    rsp_rec_t rsp_log[$];
    acc_rec_t acc_log[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [1:0] hs_req   = 2'b00;
    logic [1:0] drv_busy = 2'b00;
    logic [1:0] rr_val   = 2'b11;
    bit         rr_rand  = 1'b0;
    int         gap_pct  = 0;

    // reference arbitration state
    bit         m_busy, m_owner, m_prio;
    logic [1:0] m_v, m_g, m_rdy, m_acc, m_vld;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic fail(input string nm, input string why);
        n_checks++;
        $display("FAIL %s: %s", nm, why);
    endtask

    function automatic exp_t alu_ref(input txn_t t);
        exp_t r;
        int   sh;
        sh     = int'(t.b[4:0]);
        r.data = 32'd0;
        r.err  = 1'b0;
        case (t.op)
            4'd0: r.data = t.a & t.b;
            4'd1: r.data = t.a | t.b;
            4'd2: r.data = t.a + t.b;
            4'd3: r.data = t.a ^ t.b;
            4'd4: r.data = t.a << sh;
            4'd5: r.data = t.a >> sh;
            4'd6: r.data = t.a - t.b;
            4'd7: r.data = t.a[31] ? ~((~t.a) >> sh) : (t.a >> sh);
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic push(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        txn_t t;
        t.op = op; t.a = a; t.b = b;
        pend_q[k].push_back(t);
    endtask

    // Requesters: issue queued transactions, hold them until accepted.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            drv_busy    = 2'b00;
            req_valid_i = 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (drv_busy[k] && hs_req[k]) drv_busy[k] = 1'b0;
                if (!drv_busy[k] && pend_q[k].size() > 0 &&
                    $urandom_range(99) >= gap_pct) begin
                    txn_t t;
                    t = pend_q[k].pop_front();
                    exp_q[k].push_back(alu_ref(t));
                    req_op_i[4*k +: 4]   = t.op;
                    req_a_i[32*k +: 32]  = t.a;
                    req_b_i[32*k +: 32]  = t.b;
                    drv_busy[k] = 1'b1;
                end else if (!drv_busy[k]) begin
                    req_op_i[4*k +: 4]   = 4'($urandom);
                    req_a_i[32*k +: 32]  = $urandom;
                    req_b_i[32*k +: 32]  = $urandom;
                end
            end
            req_valid_i = drv_busy;
        end
        rsp_ready_i = rr_rand ? 2'($urandom) : rr_val;
    end

    // Monitor / scoreboard, mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_owner = 1'b0; m_prio = 1'b0;
            hs_req = 2'b00;
        end else begin
            cyc++;
            m_vld = m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("rsp_valid", 32'(rsp_valid_o), 32'(m_vld));
            if (m_busy && exp_q[m_owner].size() > 0) begin
                chk("held_data", rsp_data_o, exp_q[m_owner][0].data);
                chk("held_err", 32'(rsp_err_o), 32'(exp_q[m_owner][0].err));
            end
            m_v   = req_valid_i;
            m_g   = (m_v == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : m_v;
            m_rdy = (!m_busy || rsp_ready_i[m_owner]) ? m_g : 2'b00;
            chk("req_ready", 32'(req_ready_o), 32'(m_rdy));
            for (int k = 0; k < 2; k++) begin
                if (rsp_valid_o[k] && rsp_ready_i[k]) begin
                    rsp_rec_t rr;
                    if (exp_q[k].size() == 0) begin
                        fail("rsp_unexpected", $sformatf("port %0d data %h with nothing outstanding", k, rsp_data_o));
                    end else begin
                        exp_t e;
                        e = exp_q[k].pop_front();
                        chk("rsp_data", rsp_data_o, e.data);
                        chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
                    end
                    rr.port = 1'(k); rr.data = rsp_data_o; rr.err = rsp_err_o; rr.cyc = cyc;
                    rsp_log.push_back(rr);
                end
            end
            hs_req = req_valid_i & req_ready_o;
            for (int k = 0; k < 2; k++) begin
                if (hs_req[k]) begin
                    acc_rec_t ar;
                    ar.port = 1'(k); ar.cyc = cyc;
                    acc_log.push_back(ar);
                end
            end
            m_acc = m_v & m_rdy;
            if (m_acc != 2'b00) begin
                m_busy = 1'b1; m_owner = m_acc[1]; m_prio = ~m_acc[1];
            end else if (m_busy && rsp_ready_i[m_owner]) begin
                m_busy = 1'b0;
            end
        end
    end

    // Stimulus must not change while waiting for ready.
    for (genvar k = 0; k < 2; k++) begin : g_stable
        assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid_i[k] && !req_ready_o[k]) |=>
            (req_valid_i[k] && $stable(req_op_i[4*k +: 4]) &&
             $stable(req_a_i[32*k +: 32]) && $stable(req_b_i[32*k +: 32])))
        else $error("request on port %0d changed before acceptance", k);
    end

    task automatic wait_idle(input string nm, input int budget);
        int  n;
        bit  done;
        n = 0; done = 1'b0;
        while (!done && n < budget) begin
            done = (pend_q[0].size() == 0) && (pend_q[1].size() == 0) && (drv_busy == 2'b00) &&
                   (exp_q[0].size() == 0) && (exp_q[1].size() == 0);
            if (!done) begin @(negedge clk); n++; end
        end
        if (!done) fail(nm, "timed out waiting for outstanding operations");
        @(negedge clk);
    endtask

    task automatic wait_rsp(input string nm, input int k, input int budget);
        int n;
        n = 0;
        while (!rsp_valid_o[k] && n < budget) begin @(negedge clk); n++; end
        if (!rsp_valid_o[k]) fail(nm, "timed out waiting for response valid");
    endtask

    task automatic chk_rsp(input string nm, input int idx, input logic port,
                           input logic [31:0] data, input logic err);
        if (idx >= rsp_log.size()) begin
            fail(nm, $sformatf("response %0d missing", idx));
        end else begin
            chk({nm, "_port"}, 32'(rsp_log[idx].port), 32'(port));
            chk({nm, "_data"}, rsp_log[idx].data, data);
            chk({nm, "_err"},  32'(rsp_log[idx].err), 32'(err));
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < 2; k++) begin
            pend_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("async_rst_data", rsp_data_o, 32'd0);
        chk("async_rst_err", 32'(rsp_err_o), 32'd0);
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b, ba;
        rst_n = 1'b0; req_valid_i = '0; rsp_ready_i = '0;
        req_op_i = '0; req_a_i = '0; req_b_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        rst_n = 1'b1;

        // Single ADD on port 0
        rr_val = 2'b11;
        b = rsp_log.size();
        push(0, 4'd2, 32'd5, 32'd7);
        wait_idle("t1_wait", 50);
        chk_rsp("t1_add", b, 1'b0, 32'h0000000C, 1'b0);

        // Back-to-back SUB and SRA on port 1
        b = rsp_log.size();
        push(1, 4'd6, 32'd3, 32'd5);
        push(1, 4'd7, 32'h80000000, 32'd4);
        wait_idle("t2_wait", 50);
        chk_rsp("t2_sub", b, 1'b1, 32'hFFFFFFFE, 1'b0);
        chk_rsp("t2_sra", b + 1, 1'b1, 32'hF8000000, 1'b0);
        if (rsp_log.size() >= b + 2) chk("t2_consecutive", 32'(rsp_log[b+1].cyc - rsp_log[b].cyc), 32'd1);
        else fail("t2_consecutive", "responses missing");

        // Contention straight after reset
        pulse_reset();
        b = rsp_log.size();
        push(0, 4'd2, 32'd1, 32'd1);
        push(1, 4'd3, 32'hF0, 32'hFF);
        wait_idle("t3_wait", 50);
        chk_rsp("t3_first", b, 1'b0, 32'h2, 1'b0);
        chk_rsp("t3_second", b + 1, 1'b1, 32'h0F, 1'b0);

        // Stalled response blocks the other port
        rr_val = 2'b00;
        push(0, 4'd2, 32'd9, 32'd1);
        wait_rsp("t4_wait_rsp", 0, 50);
        push(1, 4'd0, 32'hF0F0, 32'hFF00);
        repeat (4) @(negedge clk);
        chk("t4_stall_ready", 32'(req_ready_o), 32'd0);
        chk("t4_stall_data", rsp_data_o, 32'hA);
        b = rsp_log.size(); ba = acc_log.size();
        rr_val = 2'b11;
        wait_idle("t4_wait", 50);
        chk_rsp("t4_p0", b, 1'b0, 32'hA, 1'b0);
        chk_rsp("t4_p1", b + 1, 1'b1, 32'hF000, 1'b0);
        if (acc_log.size() > ba && rsp_log.size() > b) begin
            chk("t4_accept_port", 32'(acc_log[ba].port), 32'd1);
            chk("t4_accept_cycle", 32'(acc_log[ba].cyc), 32'(rsp_log[b].cyc));
        end else fail("t4_accept_cycle", "accept or response missing");

        // Illegal op then legal op
        b = rsp_log.size();
        push(1, 4'b1010, 32'hFFFFFFFF, 32'h123);
        push(1, 4'd1, 32'h1, 32'h2);
        wait_idle("t5_wait", 50);
        chk_rsp("t5_illegal", b, 1'b1, 32'h0, 1'b1);
        chk_rsp("t5_after", b + 1, 1'b1, 32'h3, 1'b0);

        // Reset while a result is held
        rr_val = 2'b00;
        push(0, 4'd2, 32'h1234, 32'h1);
        wait_rsp("t6_wait_rsp", 0, 50);
        pulse_reset();
        rr_val = 2'b11;
        b = rsp_log.size(); ba = acc_log.size();
        push(0, 4'd3, 32'hAA, 32'h55);
        push(1, 4'd6, 32'd10, 32'd4);
        wait_idle("t6_wait", 50);
        if (acc_log.size() > ba) chk("t6_first_grant", 32'(acc_log[ba].port), 32'd0);
        else fail("t6_first_grant", "no accept after reset");
        chk_rsp("t6_p0", b, 1'b0, 32'hFF, 1'b0);
        chk_rsp("t6_p1", b + 1, 1'b1, 32'd6, 1'b0);

        // Randomized traffic
        gap_pct = 30;
        rr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 2; k++) begin
                logic [3:0] op;
                logic [31:0] bb;
                op = ($urandom_range(9) == 0) ? 4'(8 + $urandom_range(7)) : 4'($urandom_range(7));
                bb = ($urandom_range(3) == 0) ? 32'($urandom_range(31)) : $urandom;
                push(k, op, $urandom, bb);
            end
        end
        wait_idle("rand_wait", 20000);
        rr_rand = 1'b0;
        gap_pct = 0;
        repeat (2) @(negedge clk);
        chk("end_outstanding", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
